mux_seq_param: RTL
==================

Name: mux_seq_param

Overview:
- Registered, parametrised N:1 multiplexer; next generation of the team's 31-input, 2-bit combinational selector.
- Adds configurable channel count and width, plus a valid/ready output stage with backpressure.
- Adds an auto-scan mode that walks all channels round-robin, and out-of-range select detection.
- Sits between a bank of status/data sources and a single downstream consumer.

Parameters:
- NUM_INPUTS, 31, number of input channels. Legal range is 2..(2**SEL_W).
- DATA_W, 2, width of each channel in bits.
- SEL_W, 5, width of the select and index fields.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  block enable. When 0, no new beats are issued.
- mode  input  1  0 = DIRECT (sel-driven), 1 = SCAN (auto round-robin).
- sel  input  SEL_W  channel select, used in DIRECT mode.
- sel_valid  input  1  sel is valid this cycle (DIRECT mode request).
- inp  input  NUM_INPUTS*DATA_W  flattened inputs. Channel k occupies bits [k*DATA_W +: DATA_W].
- out  output  DATA_W  registered selected data.
- out_idx  output  SEL_W  channel index for the current out beat.
- out_valid  output  1  out, out_idx and sel_err hold a beat.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- sel_err  output  1  current beat came from an out-of-range sel.

Behaviour:
- Reset (asynchronous, any time): clear all of the following.
  - out = 0, out_idx = 0, out_valid = 0, sel_err = 0.
  - Scan counter = 0, state = IDLE.
  - Any in-flight beat is dropped.
- slot_free = !out_valid || out_ready. All beat issue is gated by slot_free.
- Stall: while out_valid && !out_ready, out, out_idx and sel_err hold stable. Inputs are ignored.
- State machine, evaluated every clock:
  - IDLE: no beats issued.
    - en=1 && mode=0 -> DIRECT.
    - en=1 && mode=1 -> SCAN with scan counter = 0.
  - DIRECT: mode=1 -> SCAN with scan counter = 0.
  - SCAN: mode=0 -> DIRECT.
  - en=0 in DIRECT or SCAN -> IDLE. A pending beat stays until accepted.
- Mode and state changes take effect only on cycles where slot_free=1. Otherwise they are deferred.
- DIRECT issue: in state DIRECT with sel_valid && slot_free, the next edge loads:
  - out_idx = sel and out_valid = 1.
  - If sel < NUM_INPUTS: out = channel[sel] as sampled at that edge, sel_err = 0.
  - If sel >= NUM_INPUTS: out = 0, sel_err = 1.
  - If sel_valid=0 while slot_free, out_valid goes 0 next edge.
- SCAN issue: in state SCAN with slot_free, the next edge loads:
  - out = channel[cnt], out_idx = cnt, out_valid = 1, sel_err = 0.
  - cnt advances to cnt+1, wrapping to 0 after NUM_INPUTS-1.
  - The counter never visits out-of-range indices. sel and sel_valid are ignored.
- Latency: 1 clock from request/slot_free to out_valid.
- Throughput: 1 beat per clock when out_ready is held at 1.
- Entering SCAN from IDLE or DIRECT always restarts at channel 0.
- Re-entering DIRECT from SCAN discards the scan position.
- Simultaneous accept and new request: back-to-back beats, no bubble.
- Data is sampled at issue, not at accept. Later changes on inp do not affect a held beat.

Test Plan:
- Reset and DIRECT sweep: assert reset mid-stream, then release with out_ready=1, en=1, mode=0, inp channel k = k%4. Drive sel 0..30 with sel_valid=1 -> each beat one cycle later has out=k%4, out_idx=k, sel_err=0. Asserting reset clears out_valid immediately without waiting for a clock.
- Out-of-range select: sel=31, sel_valid=1 -> out=0, out_idx=31, sel_err=1, out_valid=1. The next beat with sel=3 -> sel_err=0.
- SCAN wrap: mode=1, out_ready=1, 35 cycles -> out_idx sequence is 0..30 then 0,1,2,3, and out matches each channel. No index 31 ever appears.
- Backpressure: in SCAN, hold out_ready=0 for 5 cycles at idx=7 while changing inp[7] -> out/out_idx stay at the sampled idx-7 value. After release, idx 8 follows the next cycle with no skipped index.
- Mode switch: SCAN at idx=12, switch to mode=0 with sel=2, then back to mode=1 -> DIRECT beat shows out_idx=2, and the resumed scan starts at idx=0.
- Enable and stall: en=0 while a beat is stalled -> the beat is held until accepted, then out_valid=0 and no further beats. Parameter build NUM_INPUTS=5, DATA_W=8, SEL_W=3 -> scan wraps after idx 4, and sel=5..7 set sel_err.

Source files
------------

// File: rtl/mux_seq_param_if.sv
// Request/stream bundle for the registered N:1 multiplexer: select/scan controls in,
// one valid/ready output beat out.
interface mux_seq_param_if #(
  parameter int NUM_INPUTS = 31,
  parameter int DATA_W     = 2,
  parameter int SEL_W      = 5
);
  logic                           en;
  logic                           mode;
  logic [SEL_W-1:0]               sel;
  logic                           sel_valid;
  logic [NUM_INPUTS*DATA_W-1:0]   inp;
  logic [DATA_W-1:0]              out;
  logic [SEL_W-1:0]               out_idx;
  logic                           out_valid;
  logic                           out_ready;
  logic                           sel_err;

  // Source bank / controller side: drives requests, consumes the beat.
  modport master (
    output en, mode, sel, sel_valid, inp, out_ready,
    input  out, out_idx, out_valid, sel_err
  );

  // Multiplexer side.
  modport slave (
    input  en, mode, sel, sel_valid, inp, out_ready,
    output out, out_idx, out_valid, sel_err
  );
endinterface

// File: rtl/mux_seq_param.sv
// Registered parametrised N:1 multiplexer with DIRECT (sel-driven) and SCAN (round-robin)
// modes, out-of-range select flagging and a valid/ready output stage with backpressure.
module mux_seq_param #(
  parameter int NUM_INPUTS = 31,
  parameter int DATA_W     = 2,
  parameter int SEL_W      = 5
) (
  input  logic          clk,
  input  logic          reset,
  mux_seq_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  localparam logic [SEL_W:0]   N_EXT = (SEL_W+1)'(NUM_INPUTS);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_INPUTS - 1);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] out_q, out_nxt;
  logic [SEL_W-1:0]  idx_q, idx_nxt;
  logic              valid_q, valid_nxt;
  logic              err_q, err_nxt;

  logic              slot_free;
  logic [SEL_W-1:0]  pick;
  logic              pick_in_range;
  logic [DATA_W-1:0] pick_data;

  assign slot_free     = !valid_q || bus.out_ready;
  assign pick          = (state == SCAN) ? cnt : bus.sel;
  assign pick_in_range = {1'b0, pick} < N_EXT;

  // One shared channel mux serves both modes; the scan counter never leaves range.
  always_comb begin
    pick_data = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (pick == SEL_W'(k)) begin
        pick_data = bus.inp[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out_q;
    idx_nxt   = idx_q;
    valid_nxt = valid_q;
    err_nxt   = err_q;

    if (slot_free) begin
      valid_nxt = 1'b0;

      if (bus.en && state == DIRECT && bus.sel_valid) begin
        valid_nxt = 1'b1;
        idx_nxt   = bus.sel;
        out_nxt   = pick_in_range ? pick_data : '0;
        err_nxt   = !pick_in_range;
      end else if (bus.en && state == SCAN) begin
        valid_nxt = 1'b1;
        idx_nxt   = cnt;
        out_nxt   = pick_data;
        err_nxt   = 1'b0;
        cnt_nxt   = (cnt == LAST) ? '0 : cnt + SEL_W'(1);
      end

      // Mode changes land on the same edge as the beat issued under the old state.
      if (!bus.en) begin
        state_nxt = IDLE;
      end else if (bus.mode) begin
        if (state != SCAN) begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
        end
      end else begin
        state_nxt = DIRECT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      out_q   <= out_nxt;
      idx_q   <= idx_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.sel_err   = err_q;

endmodule
